// File: rtl/swd_xfer_ctl.sv
// swd_xfer_ctl: sequences one SWD transfer per host command through the line engine,
// re-issuing on WAIT up to a per-command limit and returning the final ack/data.
module swd_xfer_ctl #(
    parameter int RETRY_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_addr32,
    input  logic               cmd_rnw,
    input  logic               cmd_apndp,
    input  logic [31:0]        cmd_wdata,
    input  logic [RETRY_W-1:0] wait_retries,
    input  logic               abort,
    output logic [1:0]         if_addr32,
    output logic               if_rnw,
    output logic               if_apndp,
    output logic [31:0]        if_dwrite,
    output logic               if_go,
    input  logic               if_idle,
    input  logic [2:0]         if_ack,
    input  logic [31:0]        if_dread,
    input  logic               if_perr,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2:0]         rsp_ack,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_perr,
    output logic [RETRY_W-1:0] rsp_retries
);
    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_BUSY, S_EVAL, S_RESP} state_t;
    localparam logic [2:0] ACK_OK   = 3'b001;
    localparam logic [2:0] ACK_WAIT = 3'b010;
    state_t             state, state_nx;
    logic [RETRY_W-1:0] limit, retry_cnt;
    logic               abort_req, retry;
    assign rsp_retries = retry_cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        if_go     = 1'b0;
        rsp_valid = 1'b0;
        retry     = if_ack == ACK_WAIT && !abort && !abort_req && retry_cnt < limit;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                state_nx  = cmd_valid ? S_LAUNCH : S_IDLE;
            end
            S_LAUNCH: begin
                if_go    = 1'b1;
                state_nx = if_idle ? S_LAUNCH : S_BUSY;
            end
            S_BUSY:  state_nx = if_idle ? S_EVAL : S_BUSY;
            S_EVAL:  state_nx = retry ? S_LAUNCH : S_RESP;
            S_RESP: begin
                rsp_valid = 1'b1;
                state_nx  = rsp_ready ? S_IDLE : S_RESP;
            end
            default: state_nx = S_IDLE;
        endcase
    end
    // abort is latched while a transfer is in flight so a short pulse still ends retrying at S_EVAL
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            if_addr32 <= '0;
            if_rnw    <= 1'b0;
            if_apndp  <= 1'b0;
            if_dwrite <= '0;
            limit     <= '0;
            retry_cnt <= '0;
            abort_req <= 1'b0;
            rsp_ack   <= '0;
            rsp_rdata <= '0;
            rsp_perr  <= 1'b0;
        end else begin
            if (state == S_IDLE && cmd_valid) begin
                if_addr32 <= cmd_addr32;
                if_rnw    <= cmd_rnw;
                if_apndp  <= cmd_apndp;
                if_dwrite <= cmd_wdata;
                limit     <= wait_retries;
                retry_cnt <= '0;
                abort_req <= 1'b0;
            end
            if ((state == S_LAUNCH || state == S_BUSY) && abort) abort_req <= 1'b1;
            if (state == S_EVAL) begin
                rsp_ack   <= if_ack;
                rsp_rdata <= (if_rnw && if_ack == ACK_OK) ? if_dread : 32'h0;
                rsp_perr  <= if_rnw & if_perr;
                if (retry) retry_cnt <= &retry_cnt ? retry_cnt : retry_cnt + 1'b1;
            end
        end
endmodule

// File: tb/tb_swd_xfer_ctl.sv
// tb_swd_xfer_ctl: directed commands against a scripted line-engine model; expected
// responses are queued at issue and checked by a monitor on each response handshake.
module tb_swd_xfer_ctl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_rnw = 1'b0, cmd_apndp = 1'b0, abort = 1'b0;
    logic [1:0]  cmd_addr32 = '0, if_addr32;
    logic [31:0] cmd_wdata = '0, if_dwrite, rsp_rdata;
    logic [7:0]  wait_retries = '0, rsp_retries;
    logic        if_rnw, if_apndp, if_go, rsp_valid, rsp_perr, rsp_ready = 1'b1;
    logic [2:0]  rsp_ack;
    logic        e_idle, e_perr = 1'b0;
    logic [2:0]  e_ack = '0;
    logic [31:0] e_dread = '0;
    int          e_cnt, go_total = 0, base = 0, n_wait = 0;
    logic [2:0]  f_ack = 3'b001;
    logic [31:0] m_dread = '0;
    logic        m_perr = 1'b0;
    int          errors = 0, checks = 0;

    typedef struct {
        logic [2:0]  ack;
        logic [31:0] rd;
        logic        pe;
        logic [7:0]  ret;
        int          go;
        logic [1:0]  a;
        logic        rnw, ap;
        logic [31:0] wd;
    } exp_t;
    exp_t q[$];
    exp_t m_e;

    always #5 clk = ~clk;

    swd_xfer_ctl #(.RETRY_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr32(cmd_addr32), .cmd_rnw(cmd_rnw), .cmd_apndp(cmd_apndp), .cmd_wdata(cmd_wdata),
        .wait_retries(wait_retries), .abort(abort), .if_addr32(if_addr32), .if_rnw(if_rnw),
        .if_apndp(if_apndp), .if_dwrite(if_dwrite), .if_go(if_go), .if_idle(e_idle),
        .if_ack(e_ack), .if_dread(e_dread), .if_perr(e_perr), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_ack(rsp_ack), .rsp_rdata(rsp_rdata), .rsp_perr(rsp_perr),
        .rsp_retries(rsp_retries)
    );

    // line engine model: WAIT for the first n_wait transfers of a command, then f_ack
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            e_idle <= 1'b1;
            e_cnt  <= 0;
        end else if (e_idle && if_go) begin
            e_idle   <= 1'b0;
            e_cnt    <= 3;
            go_total <= go_total + 1;
        end else if (!e_idle) begin
            if (e_cnt == 0) begin
                e_idle  <= 1'b1;
                e_ack   <= (go_total - base <= n_wait) ? 3'b010 : f_ack;
                e_dread <= m_dread;
                e_perr  <= m_perr;
            end else e_cnt <= e_cnt - 1;
        end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk)
        if (rst_n && rsp_valid && rsp_ready) begin
            if (q.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
            else begin
                m_e = q.pop_front();
                check("rsp_ack", {29'd0, rsp_ack}, {29'd0, m_e.ack});
                check("rsp_rdata", rsp_rdata, m_e.rd);
                check("rsp_perr", {31'd0, rsp_perr}, {31'd0, m_e.pe});
                check("rsp_retries", {24'd0, rsp_retries}, {24'd0, m_e.ret});
                check("go_count", go_total, m_e.go);
                check("if_fields", {if_addr32, if_rnw, if_apndp}, {m_e.a, m_e.rnw, m_e.ap});
                check("if_dwrite", if_dwrite, m_e.wd);
            end
        end

    task automatic issue(input logic [1:0] a, input logic rnw, input logic ap, input logic [31:0] wd,
                         input logic [7:0] wr, input int nw, input logic [2:0] fa, input logic [31:0] dr,
                         input logic pe, input logic [2:0] x_ack, input logic [31:0] x_rd,
                         input logic x_pe, input logic [7:0] x_ret, input int x_go,
                         input bit hold, input bit do_abort);
        exp_t e;
        int t;
        @(posedge clk); #1;
        n_wait = nw; f_ack = fa; m_dread = dr; m_perr = pe; base = go_total;
        e.ack = x_ack; e.rd = x_rd; e.pe = x_pe; e.ret = x_ret; e.go = go_total + x_go;
        e.a = a; e.rnw = rnw; e.ap = ap; e.wd = wd;
        q.push_back(e);
        cmd_addr32 = a; cmd_rnw = rnw; cmd_apndp = ap; cmd_wdata = wd; wait_retries = wr;
        cmd_valid = 1'b1;
        @(negedge clk) check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_wdata = 32'h5A5A5A5A; cmd_addr32 = ~a; wait_retries = 8'hFF;
        rsp_ready = !hold;
        @(negedge clk) check("go_latency", {31'd0, if_go}, 32'd1);
        if (do_abort) begin
            t = 0;
            while (!(go_total - base == 2 && !e_idle) && t < 200) begin @(negedge clk); t++; end
            check("abort_wait_timeout", {31'd0, t >= 200}, 32'd0);
            @(posedge clk); #1 abort = 1'b1;
            @(posedge clk); #1 abort = 1'b0;
        end
        t = 0;
        while (!rsp_valid && t < 400) begin @(negedge clk); t++; end
        check("rsp_timeout", {31'd0, t >= 400}, 32'd0);
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                check("hold_ack", {29'd0, rsp_ack}, {29'd0, x_ack});
                check("hold_rdata", rsp_rdata, x_rd);
                check("hold_perr", {31'd0, rsp_perr}, {31'd0, x_pe});
                check("hold_retries", {24'd0, rsp_retries}, {24'd0, x_ret});
                check("hold_valid_nready", {30'd0, rsp_valid, cmd_ready}, 32'b10);
                @(negedge clk);
            end
            @(posedge clk); #1 rsp_ready = 1'b1;
            @(negedge clk);
        end
        @(negedge clk) check("idle_after_rsp", {30'd0, cmd_ready, rsp_valid}, 32'b10);
        rsp_ready = 1'b1;
    endtask

    initial begin
        int t;
        #3;
        check("rst_outputs", {29'd0, cmd_ready, if_go, rsp_valid}, 32'b100);
        check("rst_rsp", {rsp_ack, rsp_perr, rsp_retries}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_if", {if_addr32, if_rnw, if_apndp} ^ if_dwrite, 32'd0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        issue(2'b01, 1'b1, 1'b1, 32'h0, 8'd0, 0, 3'b001, 32'hDEADBEEF, 1'b0,
              3'b001, 32'hDEADBEEF, 1'b0, 8'd0, 1, 1'b0, 1'b0);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        issue(2'b10, 1'b0, 1'b0, 32'h12345678, 8'd3, 2, 3'b001, 32'hAAAA5555, 1'b0,
              3'b001, 32'h0, 1'b0, 8'd2, 3, 1'b0, 1'b0);
        issue(2'b11, 1'b0, 1'b1, 32'hCAFEF00D, 8'd2, 255, 3'b001, 32'h0, 1'b0,
              3'b010, 32'h0, 1'b0, 8'd2, 3, 1'b0, 1'b0);
        issue(2'b00, 1'b1, 1'b0, 32'h0, 8'd5, 0, 3'b100, 32'h13572468, 1'b0,
              3'b100, 32'h0, 1'b0, 8'd0, 1, 1'b0, 1'b0);
        issue(2'b01, 1'b1, 1'b0, 32'h0, 8'd1, 0, 3'b001, 32'h00000011, 1'b1,
              3'b001, 32'h00000011, 1'b1, 8'd0, 1, 1'b1, 1'b0);
        issue(2'b10, 1'b0, 1'b1, 32'h0F0F0F0F, 8'd0, 0, 3'b001, 32'hFFFFFFFF, 1'b1,
              3'b001, 32'h0, 1'b0, 8'd0, 1, 1'b0, 1'b0);
        issue(2'b00, 1'b1, 1'b1, 32'h0, 8'd5, 255, 3'b001, 32'h0, 1'b0,
              3'b010, 32'h0, 1'b0, 8'd1, 2, 1'b0, 1'b1);
        // reset while the line engine is busy: no response may follow
        @(posedge clk); #1;
        n_wait = 0; f_ack = 3'b001; base = go_total;
        cmd_addr32 = 2'b11; cmd_rnw = 1'b0; cmd_apndp = 1'b0; cmd_wdata = 32'h77777777;
        wait_retries = 8'd4; cmd_valid = 1'b1;
        @(posedge clk); #1 cmd_valid = 1'b0;
        t = 0;
        while (e_idle && t < 50) begin @(negedge clk); t++; end
        check("busy_timeout", {31'd0, t >= 50}, 32'd0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("midrst_outputs", {29'd0, cmd_ready, if_go, rsp_valid}, 32'b100);
        check("midrst_if", if_dwrite, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) @(negedge clk);
        check("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        issue(2'b10, 1'b1, 1'b1, 32'h0, 8'd2, 1, 3'b001, 32'h600DF00D, 1'b0,
              3'b001, 32'h600DF00D, 1'b0, 8'd1, 2, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check("scoreboard_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/swd_xfer_ctl.md
SWD_XFER_CTL -- requirements
Module: swd_xfer_ctl

Interface
REQ-001 Parameter RETRY_W, default 8, sets the width of the WAIT-retry limit and count.
REQ-002 clk  input  1  single block clock, shared with the downstream SWD line engine.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 cmd_valid / cmd_ready  input / output  1 / 1  command handshake from the host command layer.
REQ-005 cmd_addr32, cmd_rnw, cmd_apndp, cmd_wdata  input  2/1/1/32  transfer request: A[3:2], read=1, AP=1, write data.
REQ-006 wait_retries  input  RETRY_W  maximum number of re-issues after a WAIT ack; sampled at command accept.
REQ-007 abort  input  1  synchronous request to stop retrying.
REQ-008 if_addr32, if_rnw, if_apndp, if_dwrite  output  2/1/1/32  registered request fields presented to the SWD line engine.
REQ-009 if_go  output  1  transfer trigger to the line engine.
REQ-010 if_idle, if_ack, if_dread, if_perr  input  1/3/32/1  line engine idle flag, ack, read data and parity error.
REQ-011 rsp_valid / rsp_ready  output / input  1 / 1  response handshake to the host command layer.
REQ-012 rsp_ack, rsp_rdata, rsp_perr, rsp_retries  output  3/32/1/RETRY_W  final ack, read data, parity error and WAIT count used.

Function
REQ-013 The block SHALL have states S_IDLE, S_LAUNCH, S_BUSY, S_EVAL and S_RESP.
REQ-014 In S_IDLE, cmd_ready SHALL be 1; all other states drive cmd_ready=0.
REQ-015 On cmd_valid&cmd_ready, the block SHALL latch the command fields into if_* and wait_retries into a limit register, clear retry_cnt, and enter S_LAUNCH on the next cycle.
REQ-016 In S_LAUNCH, if_go SHALL be 1; the block SHALL stay in S_LAUNCH until if_idle==0 is sampled, then enter S_BUSY with if_go=0 that same cycle.
REQ-017 if_go SHALL be 0 in every state other than S_LAUNCH.
REQ-018 In S_BUSY, the block SHALL wait for if_idle==1, then enter S_EVAL.
REQ-019 In S_EVAL (one cycle), the block SHALL capture if_ack, if_dread and if_perr into the rsp_* registers.
REQ-020 From S_EVAL: if if_ack==3'b010 (WAIT), abort==0 and retry_cnt<limit, the block SHALL increment retry_cnt and enter S_LAUNCH.
REQ-021 From S_EVAL in all other cases, including OK 3'b001, FAULT 3'b100, any other ack value, or abort==1, the block SHALL enter S_RESP.
REQ-022 In S_RESP, rsp_valid SHALL be 1 and all rsp_* fields SHALL remain stable until rsp_ready==1; then the block SHALL return to S_IDLE with rsp_valid=0.
REQ-023 rsp_retries SHALL equal the number of re-issues performed; with limit=0, no retry occurs.
REQ-024 rsp_rdata SHALL equal if_dread only when cmd_rnw==1 and ack==OK; otherwise it SHALL be 32'h0.
REQ-025 rsp_perr SHALL be if_perr when cmd_rnw==1, and 0 otherwise.
REQ-026 retry_cnt SHALL saturate at 2^RETRY_W-1 and never wrap.
REQ-027 abort asserted in S_LAUNCH or S_BUSY SHALL NOT cut the in-flight transfer; it SHALL take effect at S_EVAL.
REQ-028 abort asserted in S_IDLE or S_RESP SHALL be ignored.
REQ-029 if_* request fields SHALL remain constant from accept until S_RESP exits.
REQ-030 Best-case latency from accept to if_go=1 SHALL be 1 cycle.
REQ-031 Latency from if_idle rising in S_BUSY to rsp_valid=1 SHALL be 2 cycles when no retry occurs.

Reset
REQ-032 While rst_n==0, the block SHALL be in S_IDLE, with cmd_ready=1, if_go=0, rsp_valid=0, and rsp_ack, rsp_rdata, rsp_perr, rsp_retries and if_* all 0.
REQ-033 Reset asserted mid-transfer SHALL abandon the transfer and produce no response; the line engine's own reset recovers the line.
REQ-034 The first command SHALL be accepted no earlier than the first clk edge after rst_n deasserts.

Verification
REQ-035 Read AP addr32=2'b01 with a model that ACKs OK and returns 32'hDEADBEEF, perr=0 -> single go pulse; rsp_ack=3'b001, rsp_rdata=32'hDEADBEEF, rsp_retries=0.
REQ-036 Write DP with wait_retries=3, model WAIT twice then OK -> exactly 3 go sequences; rsp_ack=3'b001, rsp_retries=2, rsp_rdata=0.
REQ-037 wait_retries=2, model always WAIT -> 3 go sequences; rsp_ack=3'b010, rsp_retries=2.
REQ-038 Model returns FAULT 3'b100 with wait_retries=5 -> no retry; rsp_ack=3'b100, rsp_retries=0.
REQ-039 Read with parity error; rsp_ready held 0 for 10 cycles -> rsp_perr=1; rsp_* fields stable; cmd_ready=0 throughout; S_IDLE one cycle after rsp_ready=1.
REQ-040 Always-WAIT model, abort pulsed during the 2nd transfer's S_BUSY -> that transfer completes; rsp_ack=3'b010, rsp_retries=1. rst_n pulsed low mid-S_BUSY -> if_go=0 and rsp_valid=0 immediately, cmd_ready=1.
